// File: rtl/arbiter_puf_pkg.sv
// rtl/arbiter_puf_pkg.sv - shared types, defaults and helpers for the arbiter-PUF engine
//
// Contents:
//   state_e            measurement FSM states
//   DEF_*              default parameter values for the engine
//   rotl()             rotate-left within a programmable width (width <= 64),
//                      used to give each chain its own challenge

package arbiter_puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_FIRE   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_RESULT = 3'd4
    } state_e;

    localparam int DEF_CHAL_W   = 8;
    localparam int DEF_N_CH     = 8;
    localparam int DEF_VOTE_CNT = 5;
    localparam int DEF_SETTLE   = 4;

    // Rotates the low 'width' bits of 'value' left by 'amount'; upper bits read 0.
    function automatic logic [63:0] rotl(input logic [63:0] value, input int width,
                                         input int amount);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width) begin
                r[6'((i + amount) % width)] = value[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arbiter_puf_engine_if.sv
// rtl/arbiter_puf_engine_if.sv - request/response handshake bundle of the arbiter-PUF engine
//
// Signals:
//   req_valid/req_ready/challenge      challenge request (master -> engine)
//   resp_valid/resp_ready/resp/stable  voted response   (engine -> master)
// Modports: master = requester (tile I/O wrapper), slave = engine.

interface arbiter_puf_engine_if #(
    parameter int CHAL_W = 8,
    parameter int N_CH   = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [CHAL_W-1:0] challenge;
    logic              resp_valid;
    logic              resp_ready;
    logic [N_CH-1:0]   resp;
    logic [N_CH-1:0]   stable;

    modport master (
        output req_valid, challenge, resp_ready,
        input  req_ready, resp_valid, resp, stable
    );

    modport slave (
        input  req_valid, challenge, resp_ready,
        output req_ready, resp_valid, resp, stable
    );

endinterface

// File: rtl/arbiter_puf_engine_puf_chain.sv
// rtl/arbiter_puf_engine_puf_chain.sv - one arbiter-PUF delay line with its arbiter flop
//
// Ports:
//   pulse      in  launch edge, fed into both paths of stage 0
//   challenge  in  CHAL_W, stage i swaps the two paths when challenge[i]=1
//   arb_q      out arbiter decision: 1 when the bottom path won the race;
//                  asynchronous to any system clock, must be synchronised

module puf_chain #(
    parameter int CHAL_W = 8
) (
    input  logic              pulse,
    input  logic [CHAL_W-1:0] challenge,
    output logic              arb_q
);

    // Each stage gets its own pair of named nets so the two race paths stay
    // physically distinct and survive optimisation.
    for (genvar i = 0; i < CHAL_W; i++) begin : g_stage
        (* keep = "true" *) logic top;
        (* keep = "true" *) logic bot;
        logic top_in;
        logic bot_in;

        if (i == 0) begin : g_first
            assign top_in = pulse;
            assign bot_in = pulse;
        end else begin : g_next
            assign top_in = g_stage[i-1].top;
            assign bot_in = g_stage[i-1].bot;
        end

        assign top = challenge[i] ? bot_in : top_in;
        assign bot = challenge[i] ? top_in : bot_in;
    end

    // The top path clocks the arbiter: bot already high means bot arrived first.
    always_ff @(posedge g_stage[CHAL_W-1].top) begin
        arb_q <= g_stage[CHAL_W-1].bot;
    end

endmodule

// File: rtl/arbiter_puf_engine.sv
// rtl/arbiter_puf_engine.sv - multi-channel arbiter-PUF measurement engine with majority vote
//
// Ports:
//   clk, rst_n   system clock, synchronous active-low reset
//   ena          tile enable; low aborts a measurement in ARM/FIRE/SAMPLE
//   bus          slave side of arbiter_puf_engine_if (request / voted response)
//   busy         measurement in progress (ARM/FIRE/SAMPLE)
//   puf_pulse    launch pulse driven into all chains
//   dbg_en       quasi-static; 1 = vote on dbg_resp instead of the arbiters
//   dbg_resp     N_CH substitute arbiter values
//
// Each evaluation: ARM (pulse low, SETTLE cycles), FIRE (pulse high,
// SETTLE+2 cycles so the arbiters resolve and the 2-flop synchronisers
// settle), SAMPLE (1 cycle, accumulate votes). VOTE_CNT evaluations are
// followed by RESULT; its first cycle registers resp/stable and raises
// resp_valid, which then holds until resp_ready.

module arbiter_puf_engine
    import arbiter_puf_pkg::*;
#(
    parameter int CHAL_W   = DEF_CHAL_W,
    parameter int N_CH     = DEF_N_CH,
    parameter int VOTE_CNT = DEF_VOTE_CNT,
    parameter int SETTLE   = DEF_SETTLE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    arbiter_puf_engine_if.slave  bus,
    output logic                 busy,
    output logic                 puf_pulse,
    input  logic                 dbg_en,
    input  logic [N_CH-1:0]      dbg_resp
);

    localparam int VW = $clog2(VOTE_CNT + 1);
    localparam int TW = $clog2(SETTLE + 3);

    localparam logic [VW-1:0] VOTE_MAX  = VW'(VOTE_CNT);
    localparam logic [VW-1:0] VOTE_HALF = VW'(VOTE_CNT / 2);
    localparam logic [TW-1:0] ARM_LAST  = TW'(SETTLE - 1);
    localparam logic [TW-1:0] FIRE_LAST = TW'(SETTLE + 1);

    state_e            state_q;
    state_e            state_d;
    logic [TW-1:0]     tmr_q;
    logic [VW-1:0]     rep_q;
    logic [VW-1:0]     vote_q [N_CH];
    logic [CHAL_W-1:0] challenge_q;
    logic [N_CH-1:0]   arb_q;
    logic [N_CH-1:0]   sync1_q;
    logic [N_CH-1:0]   sync2_q;
    logic [N_CH-1:0]   sample_bits;
    logic [N_CH-1:0]   resp_q;
    logic [N_CH-1:0]   stable_q;
    logic [N_CH-1:0]   resp_d;
    logic [N_CH-1:0]   stable_d;
    logic              resp_valid_q;
    logic              req_fire;
    logic              resp_fire;
    logic              last_rep;

    // rst_n gating keeps req_ready low while reset is held.
    assign bus.req_ready  = (state_q == ST_IDLE) & ena & rst_n;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp       = resp_q;
    assign bus.stable     = stable_q;

    assign req_fire  = bus.req_valid & bus.req_ready;
    assign resp_fire = resp_valid_q & bus.resp_ready;
    assign last_rep  = (rep_q + VW'(1)) == VOTE_MAX;

    assign sample_bits = dbg_en ? dbg_resp : sync2_q;

    // Delay chains, channel k sees the challenge rotated left by k.
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [CHAL_W-1:0] chal_k;

        assign chal_k = CHAL_W'(rotl(64'(challenge_q), CHAL_W, k % CHAL_W));

        puf_chain #(
            .CHAL_W (CHAL_W)
        ) u_chain (
            .pulse     (puf_pulse),
            .challenge (chal_k),
            .arb_q     (arb_q[k])
        );
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        puf_pulse = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                busy = 1'b1;
                if (!ena) begin
                    state_d = ST_IDLE;
                end else if (tmr_q == ARM_LAST) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                busy      = 1'b1;
                puf_pulse = 1'b1;
                if (!ena) begin
                    state_d = ST_IDLE;
                end else if (tmr_q == FIRE_LAST) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                busy      = 1'b1;
                puf_pulse = 1'b1;
                if (!ena) begin
                    state_d = ST_IDLE;
                end else if (last_rep) begin
                    state_d = ST_RESULT;
                end else begin
                    state_d = ST_ARM;
                end
            end
            ST_RESULT: begin
                if (resp_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Majority and unanimity from the finished vote counts.
    always_comb begin
        resp_d   = '0;
        stable_d = '0;
        for (int k = 0; k < N_CH; k++) begin
            resp_d[k]   = vote_q[k] > VOTE_HALF;
            stable_d[k] = (vote_q[k] == '0) | (vote_q[k] == VOTE_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            rep_q        <= '0;
            challenge_q  <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            resp_q       <= '0;
            stable_q     <= '0;
            resp_valid_q <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                vote_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            sync1_q <= arb_q;
            sync2_q <= sync1_q;

            if (req_fire) begin
                challenge_q <= bus.challenge;
            end

            // Phase timer restarts on every state change.
            if ((state_d != state_q) || !busy) begin
                tmr_q <= '0;
            end else begin
                tmr_q <= tmr_q + TW'(1);
            end

            // Entering IDLE (completion or abort) always clears the votes.
            if (state_d == ST_IDLE) begin
                rep_q <= '0;
                for (int k = 0; k < N_CH; k++) begin
                    vote_q[k] <= '0;
                end
            end else if (state_q == ST_SAMPLE) begin
                rep_q <= rep_q + VW'(1);
                for (int k = 0; k < N_CH; k++) begin
                    vote_q[k] <= vote_q[k] + VW'(sample_bits[k]);
                end
            end

            if ((state_q == ST_RESULT) && !resp_valid_q) begin
                resp_valid_q <= 1'b1;
                resp_q       <= resp_d;
                stable_q     <= stable_d;
            end else if (resp_fire) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

endmodule
